// File: rtl/mem_stall_ctrl_if.sv
// Bundle between the memory stage, the stall controller and the backing memory.
// slave  : controller view (takes stage requests, drives the backing memory)
// master : stage + memory view (drives requests and memory responses)
interface mem_stall_ctrl_if;
    localparam int unsigned W = 16;

    // memory stage side
    logic [W-1:0] Addr;
    logic [W-1:0] DataIn;
    logic         Rd;
    logic         Wr;
    logic         Halt;
    logic [W-1:0] DataOut;
    logic         Done;
    logic         Stall;
    logic         err;

    // backing memory side
    logic         mem_req;
    logic         mem_wr;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  Addr, DataIn, Rd, Wr, Halt, mem_rdata, mem_ready,
        output DataOut, Done, Stall, err, mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output Addr, DataIn, Rd, Wr, Halt, mem_rdata, mem_ready,
        input  DataOut, Done, Stall, err, mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Memory-stage stall controller: accepts one load/store at a time, issues it to
// the backing memory, waits for completion (with timeout) and freezes the
// upstream pipeline meanwhile.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_stall_ctrl_if.slave: stage request/response and memory handshake
// Parameter:
//   TIMEOUT - WAIT cycles without mem_ready before the access is abandoned (<=15)
module mem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_stall_ctrl_if.slave     bus
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [CW-1:0]   cnt_inc;
    logic [W-1:0]    addr_q, wdata_q, rdata_q;
    logic            wr_q, err_q, done_q, req_q;

    logic            accept_c;
    logic            illegal_c;
    logic            capture_c;
    logic            timeout_c;

    assign cnt_inc = CW'(cnt + CW'(1));

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        illegal_c  = 1'b0;
        capture_c  = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            IDLE: begin
                // Halt blocks both acceptance and error reporting of new requests
                if (!bus.Halt && (bus.Rd || bus.Wr)) begin
                    if ((bus.Rd && bus.Wr) || bus.Addr[0]) begin
                        illegal_c = 1'b1;
                    end else begin
                        accept_c   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    capture_c  = !wr_q;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        timeout_c  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= (state_next == DONE);
            req_q  <= (state_next == ISSUE);
            if (accept_c) begin
                addr_q  <= bus.Addr;
                wdata_q <= bus.DataIn;
                wr_q    <= bus.Wr;
            end
            if (capture_c) begin
                rdata_q <= bus.mem_rdata;
            end
            if (illegal_c || timeout_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stall must react in the same cycle a request is accepted, so it is decoded
    assign bus.Stall     = !rst && (accept_c || (state == ISSUE) || (state == WAIT));
    assign bus.DataOut   = rdata_q;
    assign bus.Done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port Addr, input, 16 bits: word address from the memory stage.
REQ-005 Port DataIn, input, 16 bits: store data from the memory stage.
REQ-006 Port Rd, input, 1 bit: load request.
REQ-007 Port Wr, input, 1 bit: store request.
REQ-008 Port Halt, input, 1 bit: processor halted; new requests are blocked.
REQ-009 Port DataOut, output, 16 bits: load result, held until the next load completes.
REQ-010 Port Done, output, 1 bit: one-cycle pulse when an access completes.
REQ-011 Port Stall, output, 1 bit: freeze the pipeline stages upstream of memory.
REQ-012 Port err, output, 1 bit: sticky error flag.
REQ-013 Port mem_req, output, 1 bit: backing-memory request strobe.
REQ-014 Port mem_wr, output, 1 bit: backing-memory write select.
REQ-015 Port mem_addr, output, 16 bits: latched address.
REQ-016 Port mem_wdata, output, 16 bits: latched store data.
REQ-017 Port mem_rdata, input, 16 bits: backing-memory read data.
REQ-018 Port mem_ready, input, 1 bit: backing-memory completion.
REQ-019 Parameter TIMEOUT, default 15: maximum number of WAIT cycles before an error is flagged.

Function
REQ-020 The FSM SHALL have four states (IDLE, ISSUE, WAIT, DONE) encoded in a 2-bit register.
REQ-021 IDLE with Rd^Wr=1, Addr[0]=0 and Halt=0 SHALL latch Addr, DataIn and the request type, then go to ISSUE.
REQ-022 Stall SHALL be 1 combinationally in the IDLE request cycle, and in every ISSUE and WAIT cycle.
REQ-023 Stall SHALL be 0 in DONE and in an IDLE cycle with no accepted request.
REQ-024 ISSUE SHALL drive mem_req=1 for exactly one cycle, with mem_wr equal to the latched type, then go to WAIT.
REQ-025 mem_addr and mem_wdata SHALL be stable from ISSUE through the end of WAIT.
REQ-026 mem_ready SHALL be sampled only in WAIT.
REQ-027 In WAIT, when mem_ready=1, the FSM SHALL go to DONE; for a load it SHALL also capture mem_rdata into DataOut.
REQ-028 DONE SHALL assert Done=1 for one cycle and then return to IDLE; a new request is not accepted in DONE.
REQ-029 Minimum latency SHALL be: request at cycle 0, ISSUE at 1, WAIT at 2, mem_ready at 2, Done at cycle 3.
REQ-030 A 4-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ready.
REQ-031 When the counter reaches TIMEOUT, err SHALL set, the FSM SHALL go to DONE, and DataOut SHALL be unchanged.
REQ-032 Rd=Wr=1 in IDLE SHALL set err, issue no access, and leave Stall=0.
REQ-033 Addr[0]=1 with a request in IDLE SHALL set err, issue no access, and leave Stall=0.
REQ-034 Once set, err SHALL hold until rst.
REQ-035 Halt=1 SHALL block acceptance in IDLE only; an access already in flight SHALL complete normally.
REQ-036 Rd, Wr, Addr and DataIn changes after acceptance SHALL be ignored until the FSM is back in IDLE.
REQ-037 mem_req SHALL be 0 in every state other than ISSUE.

Reset
REQ-038 While rst=1: state=IDLE, DataOut=0, Done=0, Stall=0, err=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-039 Reset mid-access SHALL abandon the access with no Done pulse; mem_ready arriving afterwards SHALL be ignored.
REQ-040 rst SHALL take priority over every other input.

Verification
REQ-041 Load, Addr=0x0010, mem_ready at the first WAIT cycle with mem_rdata=0xBEEF -> mem_req pulses at cycle 1; Stall=1 for cycles 0-2; Done=1 and DataOut=0xBEEF at cycle 3.
REQ-042 Store, Addr=0x0020, DataIn=0x1234, mem_ready after 3 WAIT cycles -> mem_wr=1 and mem_wdata=0x1234 during ISSUE; Done at cycle 5; DataOut unchanged.
REQ-043 Load with mem_ready never asserted -> err=1 after 15 WAIT cycles; Done pulses once; FSM returns to IDLE.
REQ-044 Rd=Wr=1 at Addr 0x0004, then separately Rd at Addr 0x0003 -> err=1; mem_req never asserted; Stall stays 0.
REQ-045 Halt=1 with Rd=1 -> no access; Halt asserted during WAIT -> the in-flight access still completes with Done.
REQ-046 rst asserted during WAIT, then mem_ready pulses -> no Done; all outputs at reset values; the next load completes normally.
